// File: rtl/demux_1to8_capture.sv
// Registered 1-to-8 demux: manual per-bit writes or an 8-bit LSB-first scan with valid/ack handoff.
// Defining DEMUX_1TO8_PARITY_EN adds a ninth serial bit checked as even parity.
module demux_1to8_capture #(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       in_i,
  input  logic [2:0] sel_i,
  input  logic       load_i,
  input  logic       start_i,
  input  logic       ack_i,
  output logic [7:0] out_o,
  output logic       busy_o,
  output logic       valid_o,
  output logic       parity_err_o
);

  // state | meaning
  // IDLE  | manual writes allowed, waiting for start
  // SCAN  | capturing bit cnt from in_i each cycle
  // PAR   | capturing the parity bit (parity build only)
  // DONE  | byte held, valid high until ack
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
`ifdef DEMUX_1TO8_PARITY_EN
  localparam logic [1:0] ST_PAR  = 2'd2;
`endif
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] out_q, out_d;
  logic       busy_q, busy_d;
  logic       valid_q, valid_d;
`ifdef DEMUX_1TO8_PARITY_EN
  logic       perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    busy_d  = busy_q;
    valid_d = valid_q;
`ifdef DEMUX_1TO8_PARITY_EN
    perr_d  = perr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SCAN;
          cnt_d   = 3'd0;
          busy_d  = 1'b1;
        end else if (load_i) begin
          out_d[sel_i] = in_i;
        end
      end
      ST_SCAN: begin
        out_d[cnt_q] = in_i;
        cnt_d        = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
`ifdef DEMUX_1TO8_PARITY_EN
          state_d = ST_PAR;
`else
          state_d = ST_DONE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
`endif
        end
      end
`ifdef DEMUX_1TO8_PARITY_EN
      ST_PAR: begin
        // odd weight across the 8 data bits plus parity bit flags an error
        perr_d  = (^out_q) ^ in_i;
        state_d = ST_DONE;
        busy_d  = 1'b0;
        valid_d = 1'b1;
      end
`endif
      ST_DONE: begin
        if (ack_i) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
`ifdef DEMUX_1TO8_PARITY_EN
          perr_d  = 1'b0;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      out_q   <= RESET_VAL;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

`ifdef DEMUX_1TO8_PARITY_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) perr_q <= 1'b0;
    else         perr_q <= perr_d;
  end
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

  assign out_o   = out_q;
  assign busy_o  = busy_q;
  assign valid_o = valid_q;

endmodule

// File: doc/demux_1to8_capture.md
# demux_1to8_capture

Registered 1-to-8 demultiplexer that routes a single input bit onto one of eight output lines. It is the receive-side counterpart of the 8-to-1 mux: the mux serialises a byte by selecting one bit at a time, and this block reassembles that stream back into a parallel byte. It supports two modes:
- **Manual write:** an external `sel` chooses the destination line.
- **Scan:** an internal counter walks `sel` from 0 to 7 and presents the assembled byte with a valid/ack handshake.

## Interface
- `RESET_VAL`, default 8'h00: value loaded into `out` on reset.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `in`  input  1  data bit to route.
- `sel`  input  3  destination line for manual write.
- `load`  input  1  manual write strobe: `out[sel]` <= `in`.
- `start`  input  1  begin a scan of 8 bits (9 bits with parity).
- `ack`  input  1  consumer accepts the assembled byte.
- `out`  output  8  registered demux outputs; reset value is `RESET_VAL`.
- `busy`  output  1  high in SCAN and PAR states; reset value 0.
- `valid`  output  1  assembled byte is available; reset value 0.
- `parity_err`  output  1  even-parity mismatch, qualified by `valid`; reset value 0.

## Operation
- **States:** IDLE, SCAN, PAR (only with the macro), DONE. Reset state is IDLE with `cnt` = 0.
- **IDLE:**
  - `start` = 1 → SCAN with `cnt` = 0. `start` has priority over `load`.
  - Otherwise, `load` = 1 → `out[sel]` <= `in`. The other 7 bits hold.
  - `ack` is ignored.
- **SCAN:**
  - Each cycle: `out[cnt]` <= `in`, then `cnt` <= `cnt` + 1 (3-bit, wraps 7→0).
  - After writing bit 7 → PAR if the macro is defined, otherwise → DONE.
  - `start`, `load` and `ack` are ignored.
- **PAR:** captures `in` as the parity bit `p`. Sets `parity_err` <= (^`out`) ^ `p`, i.e. 1 when the 9 bits have odd weight. → DONE.
- **DONE:**
  - `valid` = 1 and `out` is frozen.
  - `ack` = 1 → IDLE, `valid` <= 0, `parity_err` <= 0.
  - `start` and `load` are ignored, including when they coincide with `ack`.
- Manual writes never affect `valid` or `parity_err`.
- Asserting `reset` at any time, including mid-scan:
  - `out` = `RESET_VAL`.
  - `busy`, `valid` and `parity_err` = 0.
  - `cnt` = 0 and state = IDLE.
  - The partial byte is discarded.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- **Manual write:** `load` sampled at edge N → new `out` is visible after edge N.
- **Scan:**
  - `start` sampled at edge N → `busy` goes high after edge N.
  - Bit i is sampled from `in` at edge N+1+i, for i = 0..7.
  - Without parity: `valid` goes high and `busy` low after edge N+8.
  - With parity: parity is sampled at edge N+9, and `valid` goes high after edge N+9.
- **Handshake:** `ack` sampled high at edge M while `valid` = 1 → `valid` goes low after edge M.
  - The earliest next `start` is sampled at edge M+1.
  - Back-to-back scans take 10 cycles each without parity.
- `valid` stays high indefinitely until `ack` is sampled high.

## Configuration
- **`DEMUX_1TO8_PARITY_EN` defined:**
  - The PAR state is compiled in.
  - A scan consumes 9 serial bits.
  - `parity_err` is computed as described in Operation.
- **Not defined:**
  - PAR is absent.
  - A scan consumes 8 bits.
  - `parity_err` is tied to constant 0.
  - The port list is unchanged.

## Test plan
- **Reset mid-scan:** `RESET_VAL` = 8'hA5; run a scan for 4 bits, then assert `reset` → `out` = 8'hA5 immediately (asynchronous); `busy` = `valid` = 0. After release, the next scan starts from bit 0.
- **Manual writes:** from `out` = 8'h00, apply `in`=1,`sel`=3,`load`; then `in`=1,`sel`=0,`load`; then `in`=0,`sel`=3,`load` → `out` = 8'h08, then 8'h09, then 8'h01. `valid` stays 0 throughout.
- **Scan:** pulse `start`, then drive `in` LSB-first as 1,0,0,1,0,0,0,0 → `valid` rises exactly 8 cycles after the `start` edge with `out` = 8'h09. Hold `ack` low for 5 cycles → `valid` and `out` stay stable. Pulse `ack` → `valid` = 0 the next cycle.
- **Ignored controls:**
  - During SCAN, pulse `start` and `load` (`sel`=7, `in`=1) → `out` = 8'h09 is unchanged by them.
  - In DONE, assert `ack`+`start` together → return to IDLE with no new scan.
- **Parity, with macro:** scan 8'h09 with parity bit 0 → `valid` at cycle 9 with `parity_err` = 0. Rescan 8'h09 with parity bit 1 → `parity_err` = 1. After `ack`, `parity_err` = 0.
- **Wrap-around:** run two consecutive scans of 8'hFF and then 8'h00 → the second scan writes bit 0 first (`cnt` wrapped), and the final `out` = 8'h00.
